// File: rtl/arbitro_display_7seg.sv
// Two-writer arbiter for the four-digit 7-segment display registers.
// Grants are round-robin per packet. A packet ends on its last beat or when its writer stays idle too long.
module arbitro_display_7seg #(
  parameter int HOLD_MAX = 15,
  parameter int CW       = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Req_A,
  input  logic [1:0] i_Addr_A,
  input  logic [3:0] i_Dato_A,
  input  logic       i_Ult_A,
  output logic       o_Ack_A,
  input  logic       i_Req_B,
  input  logic [1:0] i_Addr_B,
  input  logic [3:0] i_Dato_B,
  input  logic       i_Ult_B,
  output logic       o_Ack_B,
  output logic [3:0] o_Datos1,
  output logic [3:0] o_Datos2,
  output logic [3:0] o_Datos3,
  output logic [3:0] o_Datos4,
  output logic       o_Ocupado
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_A = 2'd1,
    SERV_B = 2'd2
  } state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  state_t        state;
  logic          last_b;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    digit [4];

  logic          xfer;
  logic          xfer_ult;
  logic [1:0]    wr_addr;
  logic [3:0]    wr_dato;

  assign o_Ack_A   = (state == SERV_A) & i_Req_A;
  assign o_Ack_B   = (state == SERV_B) & i_Req_B;
  assign o_Ocupado = (state != IDLE);

  // Beat fields of whichever writer currently holds the grant.
  always_comb begin
    xfer     = 1'b0;
    xfer_ult = 1'b0;
    wr_addr  = '0;
    wr_dato  = '0;
    unique case (state)
      SERV_A: begin
        xfer     = o_Ack_A;
        xfer_ult = i_Ult_A;
        wr_addr  = i_Addr_A;
        wr_dato  = i_Dato_A;
      end
      SERV_B: begin
        xfer     = o_Ack_B;
        xfer_ult = i_Ult_B;
        wr_addr  = i_Addr_B;
        wr_dato  = i_Dato_B;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (i_Req_A && (!i_Req_B || last_b))
            state <= SERV_A;
          else if (i_Req_B)
            state <= SERV_B;
        end
        SERV_A, SERV_B: begin
          if (xfer) begin
            hold_cnt <= '0;
            if (xfer_ult) begin
              state  <= IDLE;
              last_b <= (state == SERV_B);
            end
          end else if (hold_cnt == HOLD_LAST) begin
            // HOLD_MAX-th consecutive idle cycle: give the display up.
            hold_cnt <= '0;
            state    <= IDLE;
            last_b   <= (state == SERV_B);
          end else begin
            hold_cnt <= hold_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int unsigned i = 0; i < 4; i++)
        digit[i] <= '0;
    end else if (xfer) begin
      digit[wr_addr] <= wr_dato;
    end
  end

  assign o_Datos1 = digit[0];
  assign o_Datos2 = digit[1];
  assign o_Datos3 = digit[2];
  assign o_Datos4 = digit[3];

endmodule

// File: tb/tb_arbitro_display_7seg.sv
// Bench for arbitro_display_7seg: per-writer scoreboards of accepted beats checked against the
// digit outputs, plus directed checks of grant order, latency, timeout and reset.
module tb_arbitro_display_7seg;

  localparam int HOLD_MAX = 15;

  logic       clk = 1'b0;
  logic       i_Rst;
  logic       i_Req_A, i_Ult_A, i_Req_B, i_Ult_B;
  logic [1:0] i_Addr_A, i_Addr_B;
  logic [3:0] i_Dato_A, i_Dato_B;
  logic       o_Ack_A, o_Ack_B, o_Ocupado;
  logic [3:0] o_Datos1, o_Datos2, o_Datos3, o_Datos4;

  arbitro_display_7seg #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
    .i_Clk(clk), .i_Rst(i_Rst),
    .i_Req_A(i_Req_A), .i_Addr_A(i_Addr_A), .i_Dato_A(i_Dato_A), .i_Ult_A(i_Ult_A), .o_Ack_A(o_Ack_A),
    .i_Req_B(i_Req_B), .i_Addr_B(i_Addr_B), .i_Dato_B(i_Dato_B), .i_Ult_B(i_Ult_B), .o_Ack_B(o_Ack_B),
    .o_Datos1(o_Datos1), .o_Datos2(o_Datos2), .o_Datos3(o_Datos3), .o_Datos4(o_Datos4),
    .o_Ocupado(o_Ocupado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] addr;
    logic [3:0] val;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] digit_at(input logic [1:0] a);
    case (a)
      2'd0:    return o_Datos1;
      2'd1:    return o_Datos2;
      2'd2:    return o_Datos3;
      default: return o_Datos4;
    endcase
  endfunction

  // Scoreboard monitor: a transfer seen mid-cycle must show up on the digits one cycle later.
  initial begin
    logic  pend;
    beat_t exp_b;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        check("digit_after_xfer", {28'd0, digit_at(exp_b.addr)}, {28'd0, exp_b.val});
        pend = 1'b0;
      end
      if (i_Rst === 1'b0) begin
        check("dual_ack", {31'd0, o_Ack_A & o_Ack_B}, 32'd0);
        if (o_Ack_A === 1'b1 && i_Req_A === 1'b1) begin
          if (qa.size() == 0) check("unexpected_ack_a", 32'd1, 32'd0);
          else begin
            exp_b = qa.pop_front();
            check("beat_a_addr", {30'd0, i_Addr_A}, {30'd0, exp_b.addr});
            pend = 1'b1;
          end
        end
        if (o_Ack_B === 1'b1 && i_Req_B === 1'b1) begin
          if (qb.size() == 0) check("unexpected_ack_b", 32'd1, 32'd0);
          else begin
            exp_b = qb.pop_front();
            check("beat_b_addr", {30'd0, i_Addr_B}, {30'd0, exp_b.addr});
            pend = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic beat_a(input logic [1:0] a, input logic [3:0] d, input logic u, output int ack_cyc);
    qa.push_back('{addr: a, val: d});
    i_Req_A = 1'b1; i_Addr_A = a; i_Dato_A = d; i_Ult_A = u;
    ack_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_Ack_A === 1'b1) begin
        ack_cyc = cyc;
        break;
      end
    end
    check("ack_a_seen", {31'd0, ack_cyc >= 0}, 32'd1);
    @(posedge clk); #2;
    i_Req_A = 1'b0; i_Ult_A = 1'b0;
  endtask

  task automatic beat_b(input logic [1:0] a, input logic [3:0] d, input logic u, output int ack_cyc);
    qb.push_back('{addr: a, val: d});
    i_Req_B = 1'b1; i_Addr_B = a; i_Dato_B = d; i_Ult_B = u;
    ack_cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_Ack_B === 1'b1) begin
        ack_cyc = cyc;
        break;
      end
    end
    check("ack_b_seen", {31'd0, ack_cyc >= 0}, 32'd1);
    @(posedge clk); #2;
    i_Req_B = 1'b0; i_Ult_B = 1'b0;
  endtask

  task automatic rand_inputs();
    {i_Req_A, i_Ult_A, i_Req_B, i_Ult_B} = 4'($urandom);
    {i_Addr_A, i_Addr_B} = 4'($urandom);
    {i_Dato_A, i_Dato_B} = 8'($urandom);
  endtask

  task automatic idle_inputs();
    i_Req_A = 1'b0; i_Ult_A = 1'b0; i_Addr_A = '0; i_Dato_A = '0;
    i_Req_B = 1'b0; i_Ult_B = 1'b0; i_Addr_B = '0; i_Dato_B = '0;
  endtask

  task automatic do_reset(input bit do_check);
    i_Rst = 1'b1;
    rand_inputs();
    @(posedge clk); #2; rand_inputs();
    @(posedge clk); #2; rand_inputs();
    @(negedge clk);
    if (do_check) begin
      check("rst_datos", {16'd0, o_Datos4, o_Datos3, o_Datos2, o_Datos1}, 32'd0);
      check("rst_acks", {30'd0, o_Ack_A, o_Ack_B}, 32'd0);
      check("rst_ocupado", {31'd0, o_Ocupado}, 32'd0);
    end
    @(posedge clk); #2;
    i_Rst = 1'b0;
    idle_inputs();
    qa.delete();
    qb.delete();
  endtask

  initial begin
    int c0, ca1, ca2, ca3, cb1, cb2, n_hold, last_serv, b_ack;
    idle_inputs();

    // T1: reset with random inputs
    do_reset(1'b1);

    // T2: single A packet, grant latency and final IDLE
    c0 = cyc;
    beat_a(2'd0, 4'd5, 1'b0, ca1);
    beat_a(2'd1, 4'd7, 1'b0, ca2);
    beat_a(2'd2, 4'd9, 1'b1, ca3);
    check("t2_ack1_lat", ca1 - c0, 32'd1);
    check("t2_ack2_lat", ca2 - c0, 32'd2);
    check("t2_ack3_lat", ca3 - c0, 32'd3);
    @(negedge clk);
    check("t2_idle", {31'd0, o_Ocupado}, 32'd0);
    check("t2_datos", {16'd0, o_Datos4, o_Datos3, o_Datos2, o_Datos1}, 32'h0000_0975);
    @(posedge clk); #2;

    // T3: two ties after reset -> A, B, then A again
    do_reset(1'b0);
    for (int round = 0; round < 2; round++) begin
      c0 = cyc;
      fork
        begin
          beat_a(2'd0, 4'(round + 1), 1'b0, ca1);
          beat_a(2'd1, 4'(round + 3), 1'b1, ca2);
        end
        begin
          beat_b(2'd2, 4'(round + 5), 1'b0, cb1);
          beat_b(2'd3, 4'(round + 7), 1'b1, cb2);
        end
      join
      check("t3_a_first", ca1 - c0, 32'd1);
      check("t3_b_after_a", cb1 - ca2, 32'd2);
      check("t3_b_second", cb2 - cb1, 32'd1);
      @(posedge clk); #2;
    end

    // T4: A goes quiet, B waits; release after HOLD_MAX idle cycles
    do_reset(1'b0);
    beat_a(2'd0, 4'd6, 1'b0, ca1);
    qb.push_back('{addr: 2'd1, val: 4'd8});
    i_Req_B = 1'b1; i_Addr_B = 2'd1; i_Dato_B = 4'd8; i_Ult_B = 1'b1;
    n_hold = 0; last_serv = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_Ocupado !== 1'b1) break;
      n_hold++;
      last_serv = cyc;
    end
    check("t4_hold_cycles", n_hold, HOLD_MAX);
    b_ack = -1;
    for (int n = 0; n < 10; n++) begin
      if (o_Ack_B === 1'b1) begin
        b_ack = cyc;
        break;
      end
      @(negedge clk);
    end
    check("t4_b_ack_delay", b_ack - last_serv, 32'd2);
    @(posedge clk); #2;
    i_Req_B = 1'b0; i_Ult_B = 1'b0;
    @(negedge clk);
    check("t4_digits", {16'd0, o_Datos4, o_Datos3, o_Datos2, o_Datos1}, 32'h0000_0086);
    @(posedge clk); #2;

    // T5: reset in the middle of a B packet
    beat_b(2'd0, 4'd3, 1'b0, cb1);
    beat_b(2'd1, 4'd4, 1'b0, cb2);
    i_Req_B = 1'b1; i_Addr_B = 2'd2; i_Dato_B = 4'd5; i_Ult_B = 1'b0;
    i_Rst = 1'b1;
    @(posedge clk); #2;
    i_Rst = 1'b0;
    @(negedge clk);
    check("t5_datos", {16'd0, o_Datos4, o_Datos3, o_Datos2, o_Datos1}, 32'd0);
    check("t5_ack_b", {31'd0, o_Ack_B}, 32'd0);
    check("t5_ocupado", {31'd0, o_Ocupado}, 32'd0);
    @(posedge clk); #2;
    idle_inputs();
    qb.delete();
    repeat (3) @(posedge clk);
    #2;

    // T6: back-to-back overwrite of the top digit, others untouched
    beat_a(2'd0, 4'hA, 1'b0, ca1);
    beat_a(2'd1, 4'hB, 1'b0, ca2);
    beat_a(2'd2, 4'hC, 1'b1, ca3);
    beat_b(2'd3, 4'hF, 1'b0, cb1);
    beat_b(2'd3, 4'h2, 1'b1, cb2);
    @(negedge clk);
    check("t6_datos4", {28'd0, o_Datos4}, 32'h2);
    check("t6_no_alias", {20'd0, o_Datos3, o_Datos2, o_Datos1}, 32'h0000_0CBA);
    repeat (2) @(negedge clk);
    check("end_qa_empty", qa.size(), 32'd0);
    check("end_qb_empty", qb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
